// File: rtl/mont_pkg.sv
// -----------------------------------------------------------------------------
// mont_pkg
// Shared constants and types for the Montgomery operand stager.
//   state_e            : controller states (LOAD, START, WAIT, UNLOAD)
//   WORD_W_DEF         : default stream word width
//   OPER_W_DEF         : default operand width
//   WORDS / JOB_WORDS  : words per operand / words per job at the defaults
//   CNT_W / OUT_CNT_W  : counter widths for the input and output counters
//   cnt_width()        : clog2 that never returns zero
// -----------------------------------------------------------------------------
package mont_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  localparam int WORD_W_DEF = 32;
  localparam int OPER_W_DEF = 1024;
  localparam int WORDS      = OPER_W_DEF / WORD_W_DEF;
  localparam int JOB_WORDS  = 3 * WORDS;

  // A one-entry counter still needs one bit of storage.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W     = cnt_width(JOB_WORDS);
  localparam int OUT_CNT_W = cnt_width(WORDS);

endpackage

// File: rtl/mont_operand_stager_if.sv
// -----------------------------------------------------------------------------
// mont_operand_stager_if
// Bundles the stager's word stream, multiplier and status signals.
//   s_valid/s_ready/s_data/s_last : input word stream (host/DMA -> stager)
//   mont_a/mont_b/mont_m          : operands held for the multiplier
//   mont_start/mont_done          : one-cycle start, done with result valid
//   mont_result                   : multiplier result
//   m_valid/m_ready/m_data/m_last : result word stream (stager -> host)
//   busy/err                      : status; err is a one-cycle framing pulse
// Modports: master = stager side, slave = host plus multiplier side.
// -----------------------------------------------------------------------------
interface mont_operand_stager_if
  import mont_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int OPER_W = OPER_W_DEF
);

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;

  logic [OPER_W-1:0] mont_a;
  logic [OPER_W-1:0] mont_b;
  logic [OPER_W-1:0] mont_m;
  logic              mont_start;
  logic              mont_done;
  logic [OPER_W-1:0] mont_result;

  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;

  logic              busy;
  logic              err;

  modport master (
    input  s_valid, s_data, s_last, mont_done, mont_result, m_ready,
    output s_ready, mont_a, mont_b, mont_m, mont_start,
           m_valid, m_data, m_last, busy, err
  );

  modport slave (
    output s_valid, s_data, s_last, mont_done, mont_result, m_ready,
    input  s_ready, mont_a, mont_b, mont_m, mont_start,
           m_valid, m_data, m_last, busy, err
  );

endinterface

// File: rtl/mont_operand_stager.sv
// -----------------------------------------------------------------------------
// mont_operand_stager
// Word-serial front/back end for the Montgomery multiplier. Collects A, B and M
// (each least-significant word first) from the input stream, fires a one-cycle
// start, holds the operands until done, captures the result and streams it out
// least-significant word first.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset; aborts any job in flight
//   bus   : mont_operand_stager_if.master (streams, multiplier, busy/err)
// -----------------------------------------------------------------------------
module mont_operand_stager
  import mont_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int OPER_W = OPER_W_DEF
) (
  input logic                  clk,
  input logic                  reset,
  mont_operand_stager_if.master bus
);

  localparam int N_WORDS = OPER_W / WORD_W;
  localparam int N_JOB   = 3 * N_WORDS;
  localparam int IN_CW   = cnt_width(N_JOB);
  localparam int OUT_CW  = cnt_width(N_WORDS);

  localparam logic [IN_CW-1:0]  IN_LAST   = IN_CW'(N_JOB - 1);
  localparam logic [IN_CW-1:0]  IN_WORDS  = IN_CW'(N_WORDS);
  localparam logic [OUT_CW-1:0] OUT_LAST  = OUT_CW'(N_WORDS - 1);

  localparam logic [1:0] LOAD   = ST_LOAD;
  localparam logic [1:0] START  = ST_START;
  localparam logic [1:0] WAIT   = ST_WAIT;
  localparam logic [1:0] UNLOAD = ST_UNLOAD;

  logic [1:0]        state_q,   state_d;
  logic [IN_CW-1:0]  in_cnt_q,  in_cnt_d;
  logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
  logic              start_q,   start_d;
  logic              err_q,     err_d;

  logic [OPER_W-1:0] oper_a_q, oper_b_q, oper_m_q, result_q;

  logic              in_fire, in_is_last, out_fire, out_is_last;
  logic [1:0]        oper_sel;
  logic [OUT_CW-1:0] word_sel;

  // ---------------------------------------------------------------------------
  // Decoded handshake and status outputs
  // ---------------------------------------------------------------------------
  // s_ready and mont_start are masked by reset so the upstream and the
  // multiplier see an idle block for the whole time reset is held.
  assign bus.s_ready    = (state_q == LOAD) && !reset;
  assign bus.mont_start = start_q && !reset;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != LOAD);

  assign in_fire     = bus.s_valid && bus.s_ready;
  assign in_is_last  = (in_cnt_q == IN_LAST);
  assign oper_sel    = 2'(in_cnt_q / IN_WORDS);
  assign word_sel    = OUT_CW'(in_cnt_q % IN_WORDS);

  assign bus.m_valid = (state_q == UNLOAD);
  assign out_is_last = (out_cnt_q == OUT_LAST);
  assign bus.m_last  = bus.m_valid && out_is_last;
  assign out_fire    = bus.m_valid && bus.m_ready;
  // Held for free while stalled: the word index only moves on a handshake.
  assign bus.m_data  = result_q[out_cnt_q*WORD_W +: WORD_W];

  assign bus.mont_a  = oper_a_q;
  assign bus.mont_b  = oper_b_q;
  assign bus.mont_m  = oper_m_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    start_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_fire) begin
          if (bus.s_last != in_is_last) begin
            // Misframed job: drop it and resynchronise on the next word.
            err_d    = 1'b1;
            in_cnt_d = '0;
          end else if (in_is_last) begin
            state_d  = START;
            start_d  = 1'b1;
            in_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.mont_done) state_d = UNLOAD;
      end
      UNLOAD: begin
        if (out_fire) begin
          if (out_is_last) begin
            state_d   = LOAD;
            out_cnt_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and result storage
  // ---------------------------------------------------------------------------
  // NOTE: wide data registers carry no reset; nothing reads them before the
  // controller has written them, so a reset would only cost fan-out.
  // Operands are written only in LOAD, so they stay frozen through START/WAIT.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      case (oper_sel)
        2'd0:    oper_a_q[word_sel*WORD_W +: WORD_W] <= bus.s_data;
        2'd1:    oper_b_q[word_sel*WORD_W +: WORD_W] <= bus.s_data;
        default: oper_m_q[word_sel*WORD_W +: WORD_W] <= bus.s_data;
      endcase
    end
    if (!reset && (state_q == WAIT) && bus.mont_done) begin
      result_q <= bus.mont_result;
    end
  end

endmodule

// File: tb/tb_mont_operand_stager.sv
// -----------------------------------------------------------------------------
// tb_mont_operand_stager
// Directed bench for mont_operand_stager with a stub multiplier that either
// returns a programmed value or a behavioural Montgomery product.
// -----------------------------------------------------------------------------
module tb_mont_operand_stager;
  import mont_pkg::*;

  localparam int W  = WORD_W_DEF;
  localparam int OW = OPER_W_DEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mont_operand_stager_if bus ();

  mont_operand_stager dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  bit          use_model  = 1'b0;
  int          stub_delay = 10;
  logic [OW-1:0] stub_fixed = '0;

  // Bit-serial Montgomery product a*b*2^-OW mod m (m odd, a,b < m).
  function automatic logic [OW-1:0] mont_model(input logic [OW-1:0] a, b, m);
    logic [OW+1:0] t;
    t = '0;
    for (int i = 0; i < OW; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[OW-1:0];
  endfunction

  function automatic logic [OW-1:0] ramp(input logic [W-1:0] base);
    logic [OW-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*W +: W] = base + W'(i);
    return v;
  endfunction

  function automatic int first_diff(input logic [OW-1:0] x, y);
    for (int i = 0; i < WORDS; i++) if (x[i*W +: W] !== y[i*W +: W]) return i;
    return -1;
  endfunction

  // Start monitor: counts cycles with mont_start high.
  always @(negedge clk) if (bus.mont_start === 1'b1) start_cnt <= start_cnt + 1;

  // Stub multiplier: sole driver of mont_done / mont_result.
  initial begin
    logic [OW-1:0] r;
    bus.mont_done   = 1'b0;
    bus.mont_result = '0;
    forever begin
      @(negedge clk);
      if (bus.mont_start === 1'b1) begin
        r = use_model ? mont_model(bus.mont_a, bus.mont_b, bus.mont_m) : stub_fixed;
        repeat (stub_delay) @(posedge clk);
        #1;
        bus.mont_done   = 1'b1;
        bus.mont_result = r;
        @(posedge clk);
        #1;
        bus.mont_done   = 1'b0;
        bus.mont_result = '0;
      end
    end
  end

  // Sends words 0..n_words-1 of a job; s_last is inverted on word bad_idx.
  // Called at a negedge, returns at the negedge after the last handshake.
  task automatic send_job(input logic [OW-1:0] a, b, m, input int n_words,
                          input int bad_idx, input int gap_max);
    for (int k = 0; k < n_words; k++) begin
      logic [OW-1:0] op;
      logic          lst;
      int            n;
      op  = (k < WORDS) ? a : (k < 2*WORDS) ? b : m;
      lst = (k == JOB_WORDS-1);
      if (k == bad_idx) lst = ~lst;
      if (gap_max > 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = op[(k % WORDS)*W +: W];
      bus.s_last  = lst;
      n = 0;
      while (bus.s_ready !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 2000) begin
        errors++;
        $display("FAIL send_timeout word %0d s_ready %b want 1", k, bus.s_ready);
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
  endtask

  // Drains one result; checks order, m_last and hold-while-stalled.
  task automatic recv_result(input logic [OW-1:0] exp, input bit bp,
                             input string tag, output int cycles);
    int            j;
    int            n;
    bit            held_v;
    logic [W-1:0]  held;
    j = 0; n = 0; held_v = 1'b0; held = '0;
    while (j < WORDS && n < 4000) begin
      bus.m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held_v && bus.m_valid === 1'b1) begin
        checks++;
        if (bus.m_data !== held) begin
          errors++;
          $display("FAIL %s stall_hold word %0d got %h want %h", tag, j, bus.m_data, held);
        end
      end
      if (bus.m_valid === 1'b1) begin
        if (bus.m_ready) begin
          checks++;
          if (bus.m_data !== exp[j*W +: W] || bus.m_last !== (j == WORDS-1)) begin
            errors++;
            $display("FAIL %s out_word %0d got %h last %b want %h last %b", tag, j,
                     bus.m_data, bus.m_last, exp[j*W +: W], (j == WORDS-1));
          end
          j++;
          held_v = 1'b0;
        end else begin
          held   = bus.m_data;
          held_v = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.m_ready = 1'b0;
    cycles = n;
    checks++;
    if (j < WORDS) begin
      errors++;
      $display("FAIL %s recv_timeout got %0d words want %0d", tag, j, WORDS);
    end
  endtask

  // Full job: load, start, wait (optionally checking hold every cycle), unload.
  task automatic run_job(input logic [OW-1:0] a, b, m, res, input int gap,
                         input bit bp, input bit track, input string tag);
    int s0, n, cyc, d;
    s0 = start_cnt;
    stub_fixed = res;
    send_job(a, b, m, JOB_WORDS, -1, gap);
    checks++;
    if (bus.mont_start !== 1'b1) begin
      errors++;
      $display("FAIL %s start_latency got %b want 1", tag, bus.mont_start);
    end
    checks++;
    if (bus.s_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_state s_ready %b busy %b want 0 1", tag, bus.s_ready, bus.busy);
    end
    d = first_diff(bus.mont_a, a);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s operand_a word %0d got %h want %h", tag, d, bus.mont_a[d*W +: W], a[d*W +: W]);
    end
    d = first_diff(bus.mont_b, b);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s operand_b word %0d got %h want %h", tag, d, bus.mont_b[d*W +: W], b[d*W +: W]);
    end
    d = first_diff(bus.mont_m, m);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s operand_m word %0d got %h want %h", tag, d, bus.mont_m[d*W +: W], m[d*W +: W]);
    end
    @(negedge clk);
    checks++;
    if (bus.mont_start !== 1'b0) begin
      errors++;
      $display("FAIL %s start_width got %b want 0", tag, bus.mont_start);
    end
    n = 0;
    while (bus.mont_done !== 1'b1 && n < 2000) begin
      if (track) begin
        checks++;
        if (bus.s_ready !== 1'b0 || bus.mont_a !== a || bus.mont_b !== b || bus.mont_m !== m) begin
          errors++;
          $display("FAIL %s wait_hold cycle %0d s_ready %b operands_equal %b want 0 1", tag, n,
                   bus.s_ready, (bus.mont_a === a && bus.mont_b === b && bus.mont_m === m));
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s done_timeout waited %0d cycles", tag, n);
    end
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_early got %b want 0", tag, bus.m_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s result_latency got %b want 1", tag, bus.m_valid);
    end
    recv_result(res, bp, tag, cyc);
    if (!bp) begin
      checks++;
      if (cyc != WORDS) begin
        errors++;
        $display("FAIL %s unload_time got %0d want %0d", tag, cyc, WORDS);
      end
    end
    checks++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s return_to_load s_ready %b busy %b m_valid %b want 1 0 0", tag,
               bus.s_ready, bus.busy, bus.m_valid);
    end
    checks++;
    if (start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL %s start_count got %0d want %0d", tag, start_cnt - s0, 1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b0 || bus.mont_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold s_ready %b mont_start %b want 0 0", bus.s_ready, bus.mont_start);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0 ||
        bus.m_last !== 1'b0 || bus.mont_start !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values s_ready %b busy %b m_valid %b m_last %b start %b err %b want 1 0 0 0 0 0",
               bus.s_ready, bus.busy, bus.m_valid, bus.m_last, bus.mont_start, bus.err);
    end
  endtask

  task automatic test_basic();
    logic [OW-1:0] res;
    for (int i = 0; i < WORDS; i++) res[i*W +: W] = 32'hC0DE_0000 | W'(i);
    res[W-1:0]       = 32'h0000_0001;
    res[OW-1 -: W]   = 32'hDEAD_0000;
    use_model  = 1'b0;
    stub_delay = 10;
    run_job(ramp(32'h0), ramp(32'h100), ramp(32'h200), res, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    stub_delay = 7;
    run_job(ramp(32'hA5A5_0000), ramp(32'h5A5A_1000), ramp(32'h1234_2001),
            ramp(32'hBEEF_0100), 2, 1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_framing();
    int s0;
    s0 = start_cnt;
    send_job(ramp(32'h11), ramp(32'h22), ramp(32'h33), 11, 10, 0);
    checks++;
    if (bus.err !== 1'b1 || bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL early_last err %b s_ready %b busy %b want 1 1 0", bus.err, bus.s_ready, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_width got %b want 0", bus.err);
    end
    send_job(ramp(32'h44), ramp(32'h55), ramp(32'h66), JOB_WORDS, JOB_WORDS-1, 0);
    checks++;
    if (bus.err !== 1'b1 || bus.mont_start !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL missing_last err %b start %b busy %b want 1 0 0", bus.err, bus.mont_start, bus.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL framing_no_start got %0d starts want 0", start_cnt - s0);
    end
    run_job(ramp(32'h7000), ramp(32'h8000), ramp(32'h9001), ramp(32'hF00D_0000),
            0, 1'b0, 1'b0, "after_framing");
  endtask

  task automatic test_long_multiply();
    stub_delay = 540;
    run_job(ramp(32'h0303_0000), ramp(32'h0505_0000), ramp(32'h0707_0001),
            ramp(32'h600D_0000), 0, 1'b0, 1'b1, "long_multiply");
  endtask

  task automatic test_reset_mid_job();
    int n;
    stub_delay = 20;
    send_job(ramp(32'h1), ramp(32'h2), ramp(32'h3), JOB_WORDS, -1, 0);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_wait busy %b want 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.mont_start !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold s_ready %b start %b want 0 0", bus.s_ready, bus.mont_start);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after s_ready %b busy %b m_valid %b want 1 0 0",
               bus.s_ready, bus.busy, bus.m_valid);
    end
    n = 0;
    while (bus.mont_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL midreset_done_timeout waited %0d cycles", n);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin
        errors++;
        $display("FAIL late_done_ignored cycle %0d m_valid %b busy %b s_ready %b want 0 0 1",
                 i, bus.m_valid, bus.busy, bus.s_ready);
      end
    end
  endtask

  task automatic test_integration();
    logic [OW-1:0] a, b, m, exp;
    a = OW'(3);
    b = OW'(5);
    m = OW'(7);
    // 2^1024 = 2 (mod 7) so R^-1 = 4; 3*5*4 = 60 = 4 (mod 7).
    exp = OW'(4);
    use_model  = 1'b1;
    stub_delay = 20;
    run_job(a, b, m, exp, 0, 1'b0, 1'b0, "integration");
    use_model  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_framing();
    test_long_multiply();
    test_reset_mid_job();
    test_integration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
